// File: rtl/bin2hex_stream_if.sv
// rtl/bin2hex_stream_if.sv - word-in / ASCII-character-out handshake bundle
interface bin2hex_stream_if #(
   parameter int N = 32
) ();
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] in_data;
   logic         suppress_lz;
   logic         out_valid;
   logic         out_ready;
   logic [7:0]   out_char;
   logic         out_last;

   modport master (
      output in_valid, in_data, suppress_lz, out_ready,
      input  in_ready, out_valid, out_char, out_last
   );

   modport slave (
      input  in_valid, in_data, suppress_lz, out_ready,
      output in_ready, out_valid, out_char, out_last
   );
endinterface

// File: rtl/bin2hex_stream.sv
// rtl/bin2hex_stream.sv - binary word to ASCII hex character stream converter
module bin2hex_stream #(
   parameter int N      = 32,
   parameter int PREFIX = 1,
   parameter int TERM   = 1,
   parameter int LOWER  = 0
) (
   input  logic           clk,
   input  logic           rst,
   bin2hex_stream_if.slave bus
);
   localparam int ND = N / 4;
   localparam int IW = $clog2(ND) + 1;

   typedef enum logic [2:0] {ST_IDLE, ST_PFX0, ST_PFX1, ST_DIGIT, ST_TERM} state_t;

   state_t        state, state_n;
   logic [N-1:0]  data_q;
   logic [IW-1:0] idx, start_idx;
   logic [3:0]    nib;
   logic          accept, xfer;

   assign accept = bus.in_valid && (state == ST_IDLE);
   assign xfer   = bus.out_valid && bus.out_ready;

   // idx is the nibble position (0 = least significant); leading zeros are skipped by starting lower
   always_comb begin
      start_idx = '0;
      if (!bus.suppress_lz) begin
         start_idx = IW'(ND - 1);
      end else begin
         for (int i = 0; i < ND; i++) begin
            if (bus.in_data[i*4 +: 4] != 4'h0) start_idx = IW'(i);
         end
      end
   end

   always_comb begin
      nib = 4'h0;
      for (int i = 0; i < ND; i++) begin
         if (idx == IW'(i)) nib = data_q[i*4 +: 4];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         data_q <= '0;
         idx    <= '0;
      end else begin
         state <= state_n;
         if (accept) begin
            data_q <= bus.in_data;
            idx    <= start_idx;
         end else if (state == ST_DIGIT && xfer && idx != '0) begin
            idx <= idx - 1'b1;
         end
      end
   end

   always_comb begin
      state_n       = state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.out_char  = 8'h00;
      bus.out_last  = 1'b0;
      case (state)
         ST_IDLE: begin
            bus.in_ready = 1'b1;
            if (accept) state_n = (PREFIX != 0) ? ST_PFX0 : ST_DIGIT;
         end
         ST_PFX0: begin
            bus.out_valid = 1'b1;
            bus.out_char  = 8'h30;
            if (xfer) state_n = ST_PFX1;
         end
         ST_PFX1: begin
            bus.out_valid = 1'b1;
            bus.out_char  = 8'h78;
            if (xfer) state_n = ST_DIGIT;
         end
         ST_DIGIT: begin
            bus.out_valid = 1'b1;
            if (nib < 4'd10) bus.out_char = 8'h30 + {4'h0, nib};
            else             bus.out_char = ((LOWER != 0) ? 8'h57 : 8'h37) + {4'h0, nib};
            bus.out_last  = (TERM == 0) && (idx == '0);
            if (xfer && idx == '0) state_n = (TERM != 0) ? ST_TERM : ST_IDLE;
         end
         ST_TERM: begin
            bus.out_valid = 1'b1;
            bus.out_char  = 8'h0A;
            bus.out_last  = 1'b1;
            if (xfer) state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end
endmodule

// File: tb/tb_bin2hex_stream.sv
// tb/tb_bin2hex_stream.sv - directed self-checking bench for bin2hex_stream
module tb_bin2hex_stream;
   logic        clk;
   logic        rst;
   logic        iv;
   logic [31:0] din;
   logic        sup;
   logic        ordy;
   int          sel;
   int          total;
   int          bad;

   bin2hex_stream_if #(.N(32)) b0 ();
   bin2hex_stream_if #(.N(32)) b1 ();
   bin2hex_stream_if #(.N(4))  b2 ();

   bin2hex_stream #(.N(32)) u0 (.clk(clk), .rst(rst), .bus(b0));
   bin2hex_stream #(.N(32), .PREFIX(0), .TERM(0), .LOWER(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
   bin2hex_stream #(.N(4)) u2 (.clk(clk), .rst(rst), .bus(b2));

   assign b0.in_valid    = iv && (sel == 0);
   assign b1.in_valid    = iv && (sel == 1);
   assign b2.in_valid    = iv && (sel == 2);
   assign b0.in_data     = din;
   assign b1.in_data     = din;
   assign b2.in_data     = din[3:0];
   assign b0.suppress_lz = sup;
   assign b1.suppress_lz = sup;
   assign b2.suppress_lz = sup;
   assign b0.out_ready   = ordy;
   assign b1.out_ready   = ordy;
   assign b2.out_ready   = ordy;

   logic       cur_valid, cur_ready, cur_last;
   logic [7:0] cur_char;
   assign cur_valid = (sel == 0) ? b0.out_valid : (sel == 1) ? b1.out_valid : b2.out_valid;
   assign cur_ready = (sel == 0) ? b0.in_ready  : (sel == 1) ? b1.in_ready  : b2.in_ready;
   assign cur_last  = (sel == 0) ? b0.out_last  : (sel == 1) ? b1.out_last  : b2.out_last;
   assign cur_char  = (sel == 0) ? b0.out_char  : (sel == 1) ? b1.out_char  : b2.out_char;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // called at a negedge with the block idle; returns at the negedge after the accept edge
   task automatic send(input logic [31:0] d, input logic s, input string tag);
      check({tag, " in_ready before accept"}, 64'(cur_ready), 64'd1);
      iv  = 1'b1;
      din = d;
      sup = s;
      @(posedge clk);
      @(negedge clk);
      iv = 1'b0;
   endtask

   // stall=1 throttles out_ready; stop_after>0 returns after that many transfers
   task automatic recv(input string exp, input bit stall, input int stop_after, input string tag);
      int         k;
      int         cyc;
      int         lim;
      bit         was_stall;
      logic [7:0] held_char;
      logic       held_last;
      k = 0;
      cyc = 0;
      was_stall = 1'b0;
      held_char = 8'h00;
      held_last = 1'b0;
      lim = (stop_after > 0) ? stop_after : exp.len();
      while (k < lim && cyc < 200) begin
         if (stall) ordy = (cyc % 3 == 0) ? 1'b0 : 1'($urandom_range(0, 1));
         else       ordy = 1'b1;
         check($sformatf("%s valid c%0d", tag, cyc), 64'(cur_valid), 64'd1);
         check($sformatf("%s busy c%0d", tag, cyc), 64'(cur_ready), 64'd0);
         if (was_stall) begin
            check($sformatf("%s held char c%0d", tag, cyc), 64'(cur_char), 64'(held_char));
            check($sformatf("%s held last c%0d", tag, cyc), 64'(cur_last), 64'(held_last));
         end
         if (ordy) begin
            check($sformatf("%s char%0d", tag, k), 64'(cur_char), 64'(exp[k]));
            check($sformatf("%s last%0d", tag, k), 64'(cur_last), 64'(k == exp.len() - 1));
            k++;
            was_stall = 1'b0;
         end else begin
            held_char = cur_char;
            held_last = cur_last;
            was_stall = 1'b1;
         end
         @(negedge clk);
         cyc++;
      end
      ordy = 1'b1;
      check({tag, " transfers"}, 64'(k), 64'(lim));
      if (stop_after == 0) begin
         if (!stall) check({tag, " cycles"}, 64'(cyc), 64'(exp.len()));
         check({tag, " ready after"}, 64'(cur_ready), 64'd1);
         check({tag, " idle valid"}, 64'(cur_valid), 64'd0);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      iv    = 1'b0;
      din   = '0;
      sup   = 1'b0;
      ordy  = 1'b1;
      sel   = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("reset out_valid", 64'(b0.out_valid), 64'd0);
      check("reset out_last", 64'(b0.out_last), 64'd0);
      check("reset out_char", 64'(b0.out_char), 64'h00);
      check("reset in_ready", 64'(b0.in_ready), 64'd1);

      send(32'h0000ABCD, 1'b0, "full");
      recv("0x0000ABCD\n", 1'b0, 0, "full");
      send(32'h0000ABCD, 1'b1, "slz");
      recv("0xABCD\n", 1'b0, 0, "slz");
      send(32'h0000_0000, 1'b1, "zero");
      recv("0x0\n", 1'b0, 0, "zero");
      send(32'h12345678, 1'b0, "stall");
      recv("0x12345678\n", 1'b1, 0, "stall");

      send(32'h0000ABCD, 1'b0, "pre_rst");
      recv("0x0000ABCD\n", 1'b0, 3, "pre_rst");
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid rst out_valid", 64'(b0.out_valid), 64'd0);
      check("mid rst in_ready", 64'(b0.in_ready), 64'd1);
      check("mid rst out_char", 64'(b0.out_char), 64'h00);
      send(32'h0000ABCD, 1'b0, "post_rst");
      recv("0x0000ABCD\n", 1'b0, 0, "post_rst");

      sel = 1;
      send(32'hDEADBEEF, 1'b0, "lower");
      recv("deadbeef", 1'b0, 0, "lower");

      sel = 2;
      send(32'h0000000F, 1'b0, "n4");
      recv("0xF\n", 1'b0, 0, "n4");

      check("b2b in_ready", 64'(cur_ready), 64'd1);
      iv  = 1'b1;
      din = 32'h0000000F;
      sup = 1'b0;
      @(posedge clk);
      @(negedge clk);
      din = 32'h0000000A;
      recv("0xF\n", 1'b0, 0, "b2b first");
      @(posedge clk);
      @(negedge clk);
      iv = 1'b0;
      recv("0xA\n", 1'b0, 0, "b2b second");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/bin2hex_stream.md
BIN2HEX_STREAM -- requirements
Module: bin2hex_stream

Interface
REQ-001 SHALL have parameter N, default 32, input word width in bits; legal values are multiples of 4 from 4 to 64.
REQ-002 SHALL have parameter PREFIX, default 1; when 1, each word is preceded by "0x" (8'h30, 8'h78).
REQ-003 SHALL have parameter TERM, default 1; when 1, each word is followed by line feed 8'h0A.
REQ-004 SHALL have parameter LOWER, default 0; when 1, digits A-F are emitted as 8'h61-8'h66, otherwise as 8'h41-8'h46.
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 in_valid  input  1  in_data and suppress_lz are valid this cycle.
REQ-008 in_ready  output  1  block can accept a word this cycle.
REQ-009 in_data  input  N  binary word to convert.
REQ-010 suppress_lz  input  1  per-word mode: omit leading zero digits.
REQ-011 out_valid  output  1  out_char is valid this cycle.
REQ-012 out_ready  input  1  sink accepts out_char this cycle.
REQ-013 out_char  output  8  ASCII character.
REQ-014 out_last  output  1  marks the final character of the current word.

Function
REQ-015 SHALL accept a word on a cycle where in_valid and in_ready are both 1; in_data and suppress_lz SHALL be registered on that edge.
REQ-016 in_ready SHALL be 1 only in IDLE; words SHALL NOT overlap, and in_ready SHALL return to 1 on the cycle after the last character transfers.
REQ-017 FSM states SHALL be IDLE, PFX0, PFX1, DIGIT, TERM.
 - IDLE -> PFX0 on accept if PREFIX=1, else IDLE -> DIGIT.
 - PFX0 -> PFX1 -> DIGIT, one step per character transfer.
 - DIGIT -> TERM on last-digit transfer if TERM=1, else DIGIT -> IDLE.
 - TERM -> IDLE on transfer.
REQ-018 A character transfer SHALL occur when out_valid and out_ready are both 1; states SHALL advance only on a transfer.
REQ-019 The first character of a word SHALL be presented with out_valid=1 on the cycle after the accept (latency 1).
REQ-020 Each following character SHALL be presented on the cycle after the previous transfer, with no bubbles while out_ready=1.
REQ-021 While out_valid=1 and out_ready=0, out_char and out_last SHALL hold stable, and out_valid SHALL stay 1.
REQ-022 Digits SHALL be emitted MSB nibble first, N/4 digits in total, using a digit index counter of width clog2(N/4)+1.
REQ-023 With suppress_lz=1, leading zero nibbles SHALL be skipped; the first digit SHALL be the most significant nonzero nibble.
REQ-024 With suppress_lz=1 and in_data=0, exactly one "0" SHALL be emitted.
REQ-025 Skipping zeros SHALL consume no extra cycles; the start index SHALL be computed combinationally at accept and registered.
REQ-026 out_last SHALL be 1 only on the terminator when TERM=1, else only on the final digit.
REQ-027 out_valid SHALL be 0 in IDLE; in_valid in any non-IDLE state SHALL be ignored.

Reset
REQ-028 When rst=1 at a clock edge, the block SHALL enter IDLE and set outputs as follows: out_valid=0, out_last=0, out_char=8'h00, in_ready=1 on the next cycle.
REQ-029 Reset mid-word SHALL discard the remaining characters; no partial character SHALL be emitted after reset.
REQ-030 rst SHALL take priority over an accept or transfer in the same cycle.

Verification
REQ-031 N=32, defaults, suppress_lz=0, in_data=32'h0000ABCD, out_ready=1 -> "0x0000ABCD\n", 11 consecutive cycles starting at accept+1, out_last on 8'h0A.
REQ-032 Same word with suppress_lz=1 -> "0xABCD\n", 7 characters; in_data=0 with suppress_lz=1 -> "0x0\n".
REQ-033 LOWER=1, PREFIX=0, TERM=0, in_data=32'hDEADBEEF -> "deadbeef", out_last on final "f", in_ready=1 on the following cycle.
REQ-034 Random out_ready toggling during 32'h12345678 -> out_char stable while stalled, exact sequence "0x12345678\n", in_ready=0 until the last transfer.
REQ-035 rst pulsed after 3 characters have transferred -> out_valid=0 on the next cycle, in_ready=1, and the next word is emitted complete from "0".
REQ-036 N=4, in_data=4'hF -> "0xF\n"; back-to-back in_valid -> second word accepted only after the first word's out_last transfers.
